// File: rtl/std_mem_d1_reader_if.sv
// rtl/std_mem_d1_reader_if.sv - valid/ready output stream bundle for std_mem_d1_reader
interface std_mem_d1_reader_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;

    modport master (
        output out_data,
        output out_valid,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_valid,
        output out_ready
    );
endinterface

// File: rtl/std_mem_d1_reader.sv
// rtl/std_mem_d1_reader.sv - go/done burst reader draining a std_mem_d1 into a valid/ready stream (optional STD_MEM_D1_READER_CHECKSUM_EN)
module std_mem_d1_reader #(
    parameter int WIDTH    = 32,
    parameter int SIZE     = 16,
    parameter int IDX_SIZE = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                go,
    input  logic [IDX_SIZE-1:0] base,
    input  logic [IDX_SIZE:0]   count,
    output logic [IDX_SIZE-1:0] addr0,
    input  logic [WIDTH-1:0]    read_data,
    std_mem_d1_reader_if.master strm,
    output logic                busy,
`ifdef STD_MEM_D1_READER_CHECKSUM_EN
    output logic [WIDTH-1:0]    checksum,
`endif
    output logic                done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_STREAM,
        S_DONE
    } state_t;

    // Pointer wraps at SIZE, which need not be a power of two.
    localparam logic [IDX_SIZE-1:0] LAST_IDX = IDX_SIZE'(SIZE - 1);
    localparam logic [IDX_SIZE-1:0] PTR_ONE  = {{(IDX_SIZE-1){1'b0}}, 1'b1};
    localparam logic [IDX_SIZE:0]   REM_ONE  = {{IDX_SIZE{1'b0}}, 1'b1};

    state_t              state;
    state_t              state_nxt;
    logic [IDX_SIZE-1:0] ptr;
    logic [IDX_SIZE:0]   remaining;
    logic [WIDTH-1:0]    data_q;
    logic                valid_q;

    logic                accept;
    logic                load;
    logic                handshake;
    logic                slot_free;

    assign addr0          = ptr;
    assign strm.out_data  = data_q;
    assign strm.out_valid = valid_q;
    assign busy           = (state != S_IDLE);
    assign done           = (state == S_DONE);

    // Next-state and per-cycle control strobes; output slot is free when empty or being drained.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        load      = 1'b0;
        handshake = valid_q && strm.out_ready;
        slot_free = !valid_q || strm.out_ready;
        case (state)
            S_IDLE: begin
                if (go) begin
                    accept    = 1'b1;
                    state_nxt = (count != '0) ? S_STREAM : S_DONE;
                end
            end
            S_STREAM: begin
                load = (remaining != '0) && slot_free;
                if ((remaining == '0) && slot_free) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Address pointer, beat counter and the registered output word.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr       <= '0;
            remaining <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
        end else if (accept) begin
            ptr       <= base;
            remaining <= count;
        end else if (load) begin
            data_q    <= read_data;
            valid_q   <= 1'b1;
            remaining <= remaining - REM_ONE;
            ptr       <= (ptr == LAST_IDX) ? '0 : ptr + PTR_ONE;
        end else if (handshake) begin
            valid_q   <= 1'b0;
        end
    end

`ifdef STD_MEM_D1_READER_CHECKSUM_EN
    // XOR of every word that completes a handshake; restarts on each accepted go.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            checksum <= '0;
        end else if (accept) begin
            checksum <= '0;
        end else if (handshake) begin
            checksum <= checksum ^ data_q;
        end
    end
`endif

endmodule

// File: tb/tb_std_mem_d1_reader.sv
// tb/tb_std_mem_d1_reader.sv - scoreboard bench for std_mem_d1_reader
module tb_std_mem_d1_reader;

    localparam int WIDTH    = 32;
    localparam int SIZE     = 16;
    localparam int IDX_SIZE = 4;

    logic                clk;
    logic                reset_n;
    logic                go;
    logic [IDX_SIZE-1:0] base;
    logic [IDX_SIZE:0]   count;
    logic [IDX_SIZE-1:0] addr0;
    logic [WIDTH-1:0]    read_data;
    logic                busy;
    logic                done;
`ifdef STD_MEM_D1_READER_CHECKSUM_EN
    logic [WIDTH-1:0]    checksum;
`endif

    logic [WIDTH-1:0] mem [SIZE];
    logic [WIDTH-1:0] sb [$];
    logic [WIDTH-1:0] exp_word;
    logic             stall_q;
    logic [WIDTH-1:0] stall_data;
    int               checks;
    int               failures;
    int               addr_exp [4];

    std_mem_d1_reader_if #(.WIDTH(WIDTH)) s_if ();

    std_mem_d1_reader #(
        .WIDTH    (WIDTH),
        .SIZE     (SIZE),
        .IDX_SIZE (IDX_SIZE)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .go        (go),
        .base      (base),
        .count     (count),
        .addr0     (addr0),
        .read_data (read_data),
        .strm      (s_if),
        .busy      (busy),
`ifdef STD_MEM_D1_READER_CHECKSUM_EN
        .checksum  (checksum),
`endif
        .done      (done)
    );

    assign read_data = mem[addr0];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic push_burst(input int b, input int c);
        for (int i = 0; i < c; i++) begin
            sb.push_back(WIDTH'(100 + ((b + i) % SIZE)));
        end
    endtask

    // Scoreboard pop on every handshake, plus hold-stability check after a stalled beat.
    always @(negedge clk) begin
        if (stall_q) begin
            chk("hold_valid", 64'(s_if.out_valid), 64'd1);
            chk("hold_data", 64'(s_if.out_data), 64'(stall_data));
        end
        if (reset_n && s_if.out_valid && s_if.out_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_beat", 64'(s_if.out_data), 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                exp_word = sb.pop_front();
                chk("beat_data", 64'(s_if.out_data), 64'(exp_word));
            end
        end
        stall_q    <= reset_n && s_if.out_valid && !s_if.out_ready;
        stall_data <= s_if.out_data;
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "timeout");
    end

    initial begin
        checks   = 0;
        failures = 0;
        stall_q  = 1'b0;
        for (int i = 0; i < SIZE; i++) mem[i] = WIDTH'(100 + i);
        addr_exp = '{14, 15, 0, 1};
        reset_n = 1'b0;
        go      = 1'b0;
        base    = '0;
        count   = '0;
        s_if.out_ready = 1'b1;

        // reset state
        sample();
        chk("rst_valid", 64'(s_if.out_valid), 64'd0);
        chk("rst_data", 64'(s_if.out_data), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_addr", 64'(addr0), 64'd0);
        step(); reset_n = 1'b1;
        sample();

        // burst base=2 count=4, ready high
        step(); go = 1'b1; base = 4'd2; count = 5'd4; push_burst(2, 4);
        sample(); chk("b1_c0_busy", 64'(busy), 64'd0);
        step(); go = 1'b0;
        sample();
        chk("b1_c1_busy", 64'(busy), 64'd1);
        chk("b1_c1_valid", 64'(s_if.out_valid), 64'd0);
        chk("b1_c1_addr", 64'(addr0), 64'd2);
        for (int k = 2; k <= 5; k++) begin
            step(); sample();
            chk("b1_valid", 64'(s_if.out_valid), 64'd1);
            chk("b1_busy", 64'(busy), 64'd1);
        end
        step(); sample();
        chk("b1_c6_done", 64'(done), 64'd1);
        chk("b1_c6_valid", 64'(s_if.out_valid), 64'd0);
        chk("b1_c6_busy", 64'(busy), 64'd1);
        step(); sample();
        chk("b1_c7_done", 64'(done), 64'd0);
        chk("b1_c7_busy", 64'(busy), 64'd0);
        chk("b1_sb_empty", 64'(sb.size()), 64'd0);

        // same burst, ready low on cycles 3-4
        step(); go = 1'b1; base = 4'd2; count = 5'd4; push_burst(2, 4);
        sample();
        step(); go = 1'b0; sample();
        step(); sample();
        step(); s_if.out_ready = 1'b0; sample();
        chk("b2_c3_data", 64'(s_if.out_data), 64'd103);
        step(); sample();
        chk("b2_c4_valid", 64'(s_if.out_valid), 64'd1);
        chk("b2_c4_data", 64'(s_if.out_data), 64'd103);
        step(); s_if.out_ready = 1'b1; sample();
        step(); sample();
        step(); sample();
        chk("b2_c7_data", 64'(s_if.out_data), 64'd105);
        chk("b2_c7_done", 64'(done), 64'd0);
        step(); sample();
        chk("b2_c8_done", 64'(done), 64'd1);
        step(); sample();
        chk("b2_sb_empty", 64'(sb.size()), 64'd0);

        // wrap: base=14 count=4
        step(); go = 1'b1; base = 4'd14; count = 5'd4; push_burst(14, 4);
        sample();
        step(); go = 1'b0; sample();
        chk("b3_addr", 64'(addr0), 64'(addr_exp[0]));
        for (int k = 2; k <= 4; k++) begin
            step(); sample();
            chk("b3_addr", 64'(addr0), 64'(addr_exp[k-1]));
        end
        step(); sample();
        step(); sample();
        chk("b3_c6_done", 64'(done), 64'd1);
        step(); sample();
        chk("b3_sb_empty", 64'(sb.size()), 64'd0);

        // count=0
        step(); go = 1'b1; base = 4'd5; count = 5'd0;
        sample();
        step(); go = 1'b0; sample();
        chk("b4_c1_done", 64'(done), 64'd1);
        chk("b4_c1_valid", 64'(s_if.out_valid), 64'd0);
        chk("b4_c1_addr", 64'(addr0), 64'd5);
        step(); sample();
        chk("b4_c2_done", 64'(done), 64'd0);
        chk("b4_c2_busy", 64'(busy), 64'd0);
        chk("b4_c2_valid", 64'(s_if.out_valid), 64'd0);
        chk("b4_c2_addr", 64'(addr0), 64'd5);

        // asynchronous reset after two beats
        step(); go = 1'b1; base = 4'd0; count = 5'd8; push_burst(0, 8);
        sample();
        step(); go = 1'b0; sample();
        step(); sample();
        step(); sample();
        step(); reset_n = 1'b0; #1;
        chk("b5_rst_valid", 64'(s_if.out_valid), 64'd0);
        chk("b5_rst_done", 64'(done), 64'd0);
        chk("b5_rst_busy", 64'(busy), 64'd0);
        chk("b5_rst_addr", 64'(addr0), 64'd0);
        chk("b5_rst_sb_left", 64'(sb.size()), 64'd6);
        sb.delete();
        sample();
        step(); reset_n = 1'b1; sample();

        // go held high across the burst; second burst starts only from IDLE
        step(); go = 1'b1; base = 4'd0; count = 5'd2; push_burst(0, 2);
        sample();
        step(); base = 4'd7; count = 5'd9; sample();
        chk("b6_c1_addr", 64'(addr0), 64'd0);
        step(); sample();
        step(); sample();
        chk("b6_c3_data", 64'(s_if.out_data), 64'd101);
        step(); base = 4'd3; count = 5'd2; sample();
        chk("b6_c4_done", 64'(done), 64'd1);
        step(); sample();
        chk("b6_c5_busy", 64'(busy), 64'd0);
        chk("b6_c5_sb_empty", 64'(sb.size()), 64'd0);
        push_burst(3, 2);
        step(); go = 1'b0; sample();
        chk("b6_c6_busy", 64'(busy), 64'd1);
        chk("b6_c6_addr", 64'(addr0), 64'd3);
        step(); sample();
        step(); sample();
        step(); sample();
        chk("b6_c9_done", 64'(done), 64'd1);
        step(); sample();
        chk("b6_sb_empty", 64'(sb.size()), 64'd0);

`ifdef STD_MEM_D1_READER_CHECKSUM_EN
        step(); go = 1'b1; base = 4'd0; count = 5'd3; push_burst(0, 3);
        sample();
        step(); go = 1'b0; sample();
        for (int k = 2; k <= 4; k++) begin
            step(); sample();
        end
        step(); sample();
        chk("cs_done", 64'(done), 64'd1);
        chk("cs_value", 64'(checksum), 64'd103);
        step(); sample();
        chk("cs_hold", 64'(checksum), 64'd103);
        step(); go = 1'b1; base = 4'd1; count = 5'd1; push_burst(1, 1);
        sample();
        step(); go = 1'b0; sample();
        chk("cs_clear", 64'(checksum), 64'd0);
        step(); sample();
        step(); sample();
        chk("cs_done2", 64'(done), 64'd1);
        chk("cs_value2", 64'(checksum), 64'd101);
        step(); sample();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/std_mem_d1_reader.md
Name: std_mem_d1_reader

Overview:
- Sequential streaming reader that sits directly upstream of consumers of a 1-D memory primitive. It drives the memory's `addr0`, captures `read_data`, and emits the words as a valid/ready stream.
- A Calyx-style `go`/`done` pair launches a burst of `count` words starting at `base`. Addresses wrap modulo `SIZE`.
- Used by generated designs to drain a `std_mem_d1` into pipelined datapaths without hand-written address FSMs.

Parameters:
- WIDTH, 32, data word width; must match the attached memory's WIDTH.
- SIZE, 16, number of memory words; must match the memory's SIZE.
- IDX_SIZE, 4, address width; must match the memory's IDX_SIZE; SIZE <= 2^IDX_SIZE.

Ports:
- clk  input  1  clock; all state updates on posedge.
- reset_n  input  1  asynchronous, active-low reset.
- go  input  1  start request; sampled only in IDLE.
- base  input  IDX_SIZE  first address; latched on accepted go; must be < SIZE.
- count  input  IDX_SIZE+1  number of words to stream; latched on accepted go; 0..SIZE.
- addr0  output  IDX_SIZE  address to memory; equals the internal pointer register.
- read_data  input  WIDTH  combinational read data from memory (same-cycle as addr0).
- out_data  output  WIDTH  stream data, registered.
- out_valid  output  1  stream valid.
- out_ready  input  1  stream ready from consumer.
- busy  output  1  high in STREAM and DONE states.
- done  output  1  one-cycle pulse at burst completion.

Behaviour:
- Interface: one clock (`clk`); reset is asynchronous and active-low (`reset_n`).
- Reset (asserted at any time, including mid-burst):
  - state=IDLE, ptr=0, remaining=0.
  - out_valid=0, out_data=0, done=0, busy=0, addr0=0.
  - Any in-flight beat is dropped.
- States: IDLE, STREAM, DONE.
- IDLE:
  - go=1 latches ptr<=base and remaining<=count.
  - Next state is STREAM if count!=0, else DONE.
  - go=0 stays in IDLE.
- STREAM, load rule:
  - load = (remaining!=0) && (!out_valid || out_ready).
  - On load: out_data<=read_data (the word at addr0=ptr), out_valid<=1, remaining<=remaining-1.
  - Also on load: ptr<=(ptr==SIZE-1) ? 0 : ptr+1.
- STREAM, valid rule:
  - If out_valid && out_ready && !load, then out_valid<=0.
  - out_data holds stable while out_valid && !out_ready (AXI-style stability).
- STREAM, exit: when remaining==0 and (!out_valid, or out_valid && out_ready this cycle), next state is DONE.
- DONE: done=1 for exactly one cycle, then IDLE. out_valid is 0 in DONE.
- Latency:
  - go accepted at cycle 0: first out_valid at cycle 2.
  - With out_ready held high, throughput is 1 word/cycle.
  - Last handshake at cycle k gives done=1 at cycle k+1.
  - count=0 gives done=1 at cycle 1 and no beats.
- go while busy is ignored and is not queued. base and count changes while busy have no effect.
- ptr wrap: arithmetic is performed modulo SIZE, not 2^IDX_SIZE (e.g. SIZE=10, ptr=9 -> 0).
- out_ready may be high with out_valid=0; this has no effect.

Optional Feature:
- Macro: STD_MEM_D1_READER_CHECKSUM_EN.
- Defined:
  - Adds output `checksum` [WIDTH-1:0].
  - Cleared to 0 on reset and on accepted go.
  - On every out_valid&&out_ready handshake, checksum<=checksum^out_data.
  - Stable and valid while done=1; holds its value until the next accepted go.
- Undefined: port and logic absent; all other behaviour identical.

Test Plan:
- WIDTH=32, SIZE=16, mem[i]=100+i, base=2, count=4, out_ready=1, go pulse at cycle 0 -> out_data 102,103,104,105 valid cycles 2-5, done at cycle 6, busy cycles 1-6.
- Same burst with out_ready low on cycles 3-4 -> 103 held stable with out_valid=1 through cycle 4, no word skipped or duplicated, done one cycle after the 105 handshake.
- base=14, count=4 -> addr0 sequence 14,15,0,1; out_data 114,115,100,101.
- count=0 -> done=1 at cycle 1, out_valid never asserts, addr0 unchanged from latched base.
- reset_n low asynchronously mid-burst after 2 beats -> out_valid, done, busy drop immediately. A new go with base=0, count=2 after release -> 100,101 then done. Also: go held high during a burst -> no restart; the second burst begins only when go is sampled in IDLE.
- With STD_MEM_D1_READER_CHECKSUM_EN, base=0, count=3 -> checksum=100^101^102=103 at done; a new go clears it to 0.
